// File: rtl/pixel_stream_tx_if.sv
// ---------------------------------------------------------------------------
// pixel_stream_tx_if
// Bundles the host pixel handshake, the burst lanes into the edge-detection
// core, the core's result stream and the frame status of pixel_stream_tx.
//
//   in_valid, in_pixel   host -> block  one pixel per accepted cycle
//   in_ready             block -> host  block can accept a pixel
//   pixel_in0..4         block -> core  burst beat lanes (lane k = pixel 5*beat+k)
//   load_end             block -> core  last burst beat marker
//   readable, edge_out   core -> block  core result stream
//   busy                 block -> host  burst or result wait in progress
//   frame_done           block -> host  one-cycle end-of-frame pulse
//   edge_cnt             block -> host  edge pixels counted in the last frame
//   timeout_flag         block -> host  last frame ended by timeout
//
// master = host/core side, slave = pixel_stream_tx.
// ---------------------------------------------------------------------------
interface pixel_stream_tx_if #(
  parameter int BIT_LENGTH = 5
);
  logic                  in_valid;
  logic [BIT_LENGTH-1:0] in_pixel;
  logic                  in_ready;
  logic [BIT_LENGTH-1:0] pixel_in0;
  logic [BIT_LENGTH-1:0] pixel_in1;
  logic [BIT_LENGTH-1:0] pixel_in2;
  logic [BIT_LENGTH-1:0] pixel_in3;
  logic [BIT_LENGTH-1:0] pixel_in4;
  logic                  load_end;
  logic                  readable;
  logic                  edge_out;
  logic                  busy;
  logic                  frame_done;
  logic [8:0]            edge_cnt;
  logic                  timeout_flag;

  modport master (
    output in_valid, in_pixel, readable, edge_out,
    input  in_ready, pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4,
           load_end, busy, frame_done, edge_cnt, timeout_flag
  );

  modport slave (
    input  in_valid, in_pixel, readable, edge_out,
    output in_ready, pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4,
           load_end, busy, frame_done, edge_cnt, timeout_flag
  );
endinterface

// File: rtl/pixel_stream_tx.sv
// ---------------------------------------------------------------------------
// pixel_stream_tx
// Buffers one IMG_DIM x IMG_DIM frame from the host (one pixel per accepted
// cycle), bursts it into the edge-detection core LANES pixels per cycle with
// load_end on the final beat, then counts edge pixels on the core's result
// stream until readable falls or TIMEOUT WAIT cycles elapse.
//
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    pixel_stream_tx_if.slave (handshake, lanes, result stream, status)
// ---------------------------------------------------------------------------
module pixel_stream_tx #(
  parameter int IMG_DIM    = 20,
  parameter int BIT_LENGTH = 5,
  parameter int LANES      = 5,
  parameter int TIMEOUT    = 4095
) (
  input  logic             clk,
  input  logic             reset,
  pixel_stream_tx_if.slave bus
);

  localparam int NPIX    = IMG_DIM * IMG_DIM;
  localparam int ENTRIES = NPIX / LANES;
  localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WW      = LANES * BIT_LENGTH;
  localparam int TW      = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [AW-1:0] ENTRY_ZERO = AW'(0);
  localparam logic [AW-1:0] ENTRY_ONE  = AW'(1);
  localparam logic [AW-1:0] LAST_ENTRY = AW'(ENTRIES - 1);
  localparam logic [LW-1:0] LANE_ONE   = LW'(1);
  localparam logic [LW-1:0] LAST_LANE  = LW'(LANES - 1);
  localparam logic [TW-1:0] WAIT_ONE   = TW'(1);
  localparam logic [TW-1:0] LAST_WAIT  = TW'(TIMEOUT - 1);
  localparam logic [8:0]    EDGE_MAX   = 9'(NPIX);

  logic [WW-1:0] buf_mem [ENTRIES];
  logic [WW-1:0] stage_r;

  logic [1:0]    state_r;
  logic [LW-1:0] lane_r;
  logic [AW-1:0] word_r;
  logic [AW-1:0] beat_r;
  logic          ready_r;
  logic [WW-1:0] lanes_r;
  logic          load_end_r;
  logic          busy_r;
  logic          frame_done_r;
  logic [8:0]    edge_cnt_r;
  logic          timeout_flag_r;
  logic [8:0]    edge_acc_r;
  logic [TW-1:0] wait_cnt_r;
  logic          readable_d_r;

  logic          in_ready_s;
  logic          accept_s;
  logic          in_wait_s;
  logic          fall_s;
  logic          timeout_s;
  logic          edge_hit_s;
  logic [8:0]    edge_next_s;
  logic [WW-1:0] word_s;

  // in_ready is forced low while reset is asserted so nothing is offered
  // acceptance during reset; ready_r itself comes out of reset high.
  assign in_ready_s = ready_r & ~reset;
  assign accept_s   = bus.in_valid & in_ready_s;
  assign in_wait_s  = (state_r == ST_WAIT);
  // readable_d_r is held at 0 outside WAIT, so a fall is only seen in WAIT.
  assign fall_s     = in_wait_s & readable_d_r & ~bus.readable;
  assign timeout_s  = in_wait_s & (wait_cnt_r == LAST_WAIT);
  assign edge_hit_s = in_wait_s & bus.readable & bus.edge_out;

  // Staging word with the incoming pixel dropped into its lane slot.
  always_comb begin
    word_s = stage_r;
    word_s[int'(lane_r) * BIT_LENGTH +: BIT_LENGTH] = bus.in_pixel;
  end

  // Saturating edge count including this cycle's hit.
  always_comb begin
    if (edge_hit_s && (edge_acc_r != EDGE_MAX)) begin
      edge_next_s = edge_acc_r + 9'd1;
    end else begin
      edge_next_s = edge_acc_r;
    end
  end

  // Frame buffer and staging word; pure data path, contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      stage_r <= word_s;
      if (lane_r == LAST_LANE) begin
        buf_mem[word_r] <= word_s;
      end
    end
  end

  // Control FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_FILL;
      lane_r         <= '0;
      word_r         <= '0;
      beat_r         <= '0;
      ready_r        <= 1'b1;
      lanes_r        <= '0;
      load_end_r     <= 1'b0;
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
      edge_cnt_r     <= '0;
      timeout_flag_r <= 1'b0;
      edge_acc_r     <= '0;
      wait_cnt_r     <= '0;
      readable_d_r   <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      readable_d_r <= 1'b0;
      case (state_r)
        ST_FILL: begin
          ready_r    <= 1'b1;
          lanes_r    <= '0;
          load_end_r <= 1'b0;
          busy_r     <= 1'b0;
          if (accept_s) begin
            if (lane_r == LAST_LANE) begin
              lane_r <= '0;
              if (word_r == LAST_ENTRY) begin
                // Last pixel: beat 0 is presented on the very next cycle.
                word_r     <= '0;
                ready_r    <= 1'b0;
                busy_r     <= 1'b1;
                beat_r     <= ENTRY_ZERO;
                lanes_r    <= buf_mem[ENTRY_ZERO];
                load_end_r <= 1'b0;
                state_r    <= ST_BURST;
              end else begin
                word_r <= word_r + ENTRY_ONE;
              end
            end else begin
              lane_r <= lane_r + LANE_ONE;
            end
          end
        end
        ST_BURST: begin
          // beat_r is the beat currently on the lanes; fetch the next one.
          if (beat_r == LAST_ENTRY) begin
            lanes_r    <= '0;
            load_end_r <= 1'b0;
            beat_r     <= '0;
            wait_cnt_r <= '0;
            edge_acc_r <= '0;
            state_r    <= ST_WAIT;
          end else begin
            lanes_r    <= buf_mem[beat_r + ENTRY_ONE];
            load_end_r <= ((beat_r + ENTRY_ONE) == LAST_ENTRY);
            beat_r     <= beat_r + ENTRY_ONE;
          end
        end
        ST_WAIT: begin
          if (fall_s || timeout_s) begin
            // A readable fall wins over a simultaneous timeout.
            state_r        <= ST_FILL;
            busy_r         <= 1'b0;
            frame_done_r   <= 1'b1;
            edge_cnt_r     <= edge_next_s;
            timeout_flag_r <= ~fall_s;
            edge_acc_r     <= '0;
            wait_cnt_r     <= '0;
          end else begin
            readable_d_r <= bus.readable;
            edge_acc_r   <= edge_next_s;
            wait_cnt_r   <= wait_cnt_r + WAIT_ONE;
          end
        end
        default: begin
          state_r    <= ST_FILL;
          ready_r    <= 1'b1;
          lanes_r    <= '0;
          load_end_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.pixel_in0    = lanes_r[0*BIT_LENGTH +: BIT_LENGTH];
  assign bus.pixel_in1    = lanes_r[1*BIT_LENGTH +: BIT_LENGTH];
  assign bus.pixel_in2    = lanes_r[2*BIT_LENGTH +: BIT_LENGTH];
  assign bus.pixel_in3    = lanes_r[3*BIT_LENGTH +: BIT_LENGTH];
  assign bus.pixel_in4    = lanes_r[4*BIT_LENGTH +: BIT_LENGTH];
  assign bus.load_end     = load_end_r;
  assign bus.busy         = busy_r;
  assign bus.frame_done   = frame_done_r;
  assign bus.edge_cnt     = edge_cnt_r;
  assign bus.timeout_flag = timeout_flag_r;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// ---------------------------------------------------------------------------
// tb_pixel_stream_tx
// Two instances: dut_a with TIMEOUT=4095 runs the table of frames and the
// reset-mid-burst sequence, dut_b with TIMEOUT=16 runs the short-timeout
// frame. Pixel i of a frame is (i + off) mod 32.
// ---------------------------------------------------------------------------
module tb_pixel_stream_tx;

  typedef struct {
    bit use_b;     // run this frame on dut_b
    int duty;      // in_valid probability in percent during FILL
    int off;       // pixel pattern offset
    int rd_len;    // WAIT cycles with readable high (from WAIT cycle 0)
    int n_edges;   // leading readable cycles with edge_out high
    int exp_cnt;   // expected edge_cnt
    bit exp_tmo;   // expected timeout_flag
    int exp_wait;  // expected WAIT cycles up to and including the exit cycle
  } vec_t;

  logic clk;
  logic rst;
  logic in_valid;
  logic [4:0] in_pixel;
  logic readable;
  logic edge_out;
  logic sel_a;
  logic sel_b;
  logic use_b;

  int n_checks = 0;
  int n_fail = 0;
  int prev_cnt [2];
  bit prev_tmo [2];
  vec_t vecs [6];

  pixel_stream_tx_if #(.BIT_LENGTH(5)) bus_a ();
  pixel_stream_tx_if #(.BIT_LENGTH(5)) bus_b ();

  assign bus_a.in_valid = in_valid & sel_a;
  assign bus_a.in_pixel = in_pixel;
  assign bus_a.readable = readable;
  assign bus_a.edge_out = edge_out;
  assign bus_b.in_valid = in_valid & sel_b;
  assign bus_b.in_pixel = in_pixel;
  assign bus_b.readable = 1'b0;
  assign bus_b.edge_out = 1'b0;

  pixel_stream_tx #(.IMG_DIM(20), .BIT_LENGTH(5), .LANES(5), .TIMEOUT(4095)) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a)
  );
  pixel_stream_tx #(.IMG_DIM(20), .BIT_LENGTH(5), .LANES(5), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b)
  );

  logic [24:0] obs_lanes;
  logic        obs_ready, obs_le, obs_busy, obs_done, obs_tmo;
  logic [8:0]  obs_cnt;

  // Observe whichever instance the current test is exercising.
  always_comb begin
    if (use_b) begin
      obs_lanes = {bus_b.pixel_in4, bus_b.pixel_in3, bus_b.pixel_in2, bus_b.pixel_in1, bus_b.pixel_in0};
      obs_ready = bus_b.in_ready;
      obs_le    = bus_b.load_end;
      obs_busy  = bus_b.busy;
      obs_done  = bus_b.frame_done;
      obs_tmo   = bus_b.timeout_flag;
      obs_cnt   = bus_b.edge_cnt;
    end else begin
      obs_lanes = {bus_a.pixel_in4, bus_a.pixel_in3, bus_a.pixel_in2, bus_a.pixel_in1, bus_a.pixel_in0};
      obs_ready = bus_a.in_ready;
      obs_le    = bus_a.load_end;
      obs_busy  = bus_a.busy;
      obs_done  = bus_a.frame_done;
      obs_tmo   = bus_a.timeout_flag;
      obs_cnt   = bus_a.edge_cnt;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] exp_word(input int b, input int off);
    logic [24:0] w;
    for (int k = 0; k < 5; k++) begin
      w[k*5 +: 5] = 5'((5 * b + k + off) % 32);
    end
    return w;
  endfunction

  task automatic fill_frame(input int duty, input int off);
    int i = 0;
    int cyc = 0;
    while (i < 400 && cyc < 5000) begin
      check("in_ready_fill", obs_ready, 1);
      in_valid = ($urandom_range(99) < duty);
      in_pixel = 5'((i + off) % 32);
      step();
      cyc++;
      if (in_valid) i++;
    end
    check("fill_complete", i, 400);
    // Keep offering a pixel during burst/WAIT; it must not be taken.
    in_valid = 1'b1;
    in_pixel = 5'd31;
    check("in_ready_after_fill", obs_ready, 0);
    check("busy_burst_start", obs_busy, 1);
  endtask

  task automatic burst_check(input int off, input int upto);
    int les = 0;
    for (int b = 0; b <= upto; b++) begin
      check("burst_lanes", obs_lanes, exp_word(b, off));
      check("burst_load_end", obs_le, (b == 79));
      check("burst_busy", obs_busy, 1);
      les += int'(obs_le);
      if (b < upto) step();
    end
    if (upto == 79) begin
      step();
      check("post_burst_lanes", obs_lanes, 0);
      check("post_burst_load_end", obs_le, 0);
      check("wait_busy", obs_busy, 1);
      check("load_end_count", les, 1);
    end
  endtask

  task automatic wait_phase(input int rd_len, input int n_edges, input int exp_cnt,
                            input bit exp_tmo, input int exp_wait, input int d);
    int c = 0;
    bit got = 1'b0;
    check("edge_cnt_hold", obs_cnt, prev_cnt[d]);
    check("timeout_flag_hold", obs_tmo, prev_tmo[d]);
    while (!got && c < 5000) begin
      readable = (c < rd_len);
      edge_out = (c < n_edges) || (c >= rd_len);
      step();
      c++;
      if (obs_done) got = 1'b1;
    end
    readable = 1'b0;
    edge_out = 1'b0;
    in_valid = 1'b0;
    check("frame_done_seen", got, 1);
    check("wait_cycles", c, exp_wait);
    check("edge_cnt", obs_cnt, exp_cnt);
    check("timeout_flag", obs_tmo, exp_tmo);
    check("busy_at_done", obs_busy, 0);
    check("in_ready_at_done", obs_ready, 0);
    step();
    check("in_ready_after_done", obs_ready, 1);
    check("frame_done_pulse", obs_done, 0);
    check("edge_cnt_after_done", obs_cnt, exp_cnt);
    prev_cnt[d] = exp_cnt;
    prev_tmo[d] = exp_tmo;
  endtask

  initial begin
    //          use_b  duty off  rd    edges cnt  tmo   wait
    vecs[0] = '{1'b0, 100, 0, 324,  37,  37,  1'b0, 325};
    vecs[1] = '{1'b0,  50, 0,  10,   0,   0,  1'b0,  11};
    vecs[2] = '{1'b0, 100, 7,   0,   0,   0,  1'b1, 4095};
    vecs[3] = '{1'b0,  75, 3, 4094,  5,   5,  1'b0, 4095};
    vecs[4] = '{1'b0, 100, 9, 450, 420, 400,  1'b0, 451};
    vecs[5] = '{1'b1, 100, 5,   0,   0,   0,  1'b1,  16};

    rst = 1'b1;
    in_valid = 1'b0;
    in_pixel = 5'd0;
    readable = 1'b0;
    edge_out = 1'b0;
    sel_a = 1'b1;
    sel_b = 1'b0;
    use_b = 1'b0;
    prev_cnt[0] = 0; prev_cnt[1] = 0;
    prev_tmo[0] = 1'b0; prev_tmo[1] = 1'b0;

    repeat (2) step();
    check("reset_in_ready", obs_ready, 0);
    check("reset_lanes", obs_lanes, 0);
    check("reset_load_end", obs_le, 0);
    check("reset_busy", obs_busy, 0);
    check("reset_frame_done", obs_done, 0);
    check("reset_edge_cnt", obs_cnt, 0);
    check("reset_timeout_flag", obs_tmo, 0);
    rst = 1'b0;
    step();
    check("in_ready_after_reset", obs_ready, 1);

    for (int v = 0; v < 6; v++) begin
      use_b = vecs[v].use_b;
      sel_a = ~vecs[v].use_b;
      sel_b = vecs[v].use_b;
      #1;
      fill_frame(vecs[v].duty, vecs[v].off);
      burst_check(vecs[v].off, 79);
      wait_phase(vecs[v].rd_len, vecs[v].n_edges, vecs[v].exp_cnt, vecs[v].exp_tmo,
                 vecs[v].exp_wait, vecs[v].use_b ? 1 : 0);
    end

    // Reset in the middle of a burst, then a clean frame afterwards.
    use_b = 1'b0;
    sel_a = 1'b1;
    sel_b = 1'b0;
    #1;
    fill_frame(100, 2);
    burst_check(2, 40);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midreset_lanes", obs_lanes, 0);
    check("midreset_load_end", obs_le, 0);
    check("midreset_in_ready", obs_ready, 1);
    check("midreset_busy", obs_busy, 0);
    check("midreset_edge_cnt", obs_cnt, 0);
    prev_cnt[0] = 0; prev_cnt[1] = 0;
    prev_tmo[0] = 1'b0; prev_tmo[1] = 1'b0;
    fill_frame(100, 11);
    burst_check(11, 79);
    wait_phase(3, 2, 2, 1'b0, 4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
